// File: rtl/i2c_reg_master.sv
// i2c_reg_master
// Single-clock I2C controller for one-byte register writes and reads.
//   Write: START, {dev_addr,0}, reg_addr, wdata, STOP.
//   Read : START, {dev_addr,0}, reg_addr, then STOP+START (or a repeated
//          START), {dev_addr,1}, one data byte NACKed by the master, STOP.
// Each bit cell is four ticks of CLK_DIV clk cycles:
//   q0 SCL low/drive SDA, q1 SCL high, q2 SCL high/sample, q3 SCL low.
// Every transition is taken on a tick, so the tick grid never drifts.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start, rw         : command strobe (ignored while busy), 0=write 1=read
//   dev_addr, reg_addr, wdata : command operands, latched on accepted start
//   busy, done        : transaction in progress, one-cycle end pulse
//   ack_err           : target NACKed; held until the next accepted start
//   rdata             : last successfully read byte
//   scl_o, sda_o      : open-drain drives (0 = pull low, 1 = release)
//   sda_i             : synchronised SDA bus level
//
// Build option
//   I2C_REG_MASTER_RSTART_EN : reads use a repeated START instead of
//   STOP followed by a fresh START (4 ticks shorter).
module i2c_reg_master #(
  parameter int CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       scl_o,
  output logic       sda_o,
  input  logic       sda_i
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_TX, ST_ACK, ST_RX, ST_NACK, ST_STOP, ST_RSTART, ST_DONE
  } state_t;

  // Which byte of the transaction the TX/ACK states are working on.
  localparam logic [1:0] SEG_DEV_W = 2'd0;
  localparam logic [1:0] SEG_REG   = 2'd1;
  localparam logic [1:0] SEG_DATA  = 2'd2;
  localparam logic [1:0] SEG_DEV_R = 2'd3;

  function automatic logic [7:0] seg_byte(input logic [1:0] seg, input logic [6:0] dev,
                                          input logic [7:0] ra, input logic [7:0] wd);
    logic [7:0] b;
    case (seg)
      SEG_DEV_W: b = {dev, 1'b0};
      SEG_REG:   b = ra;
      SEG_DATA:  b = wd;
      default:   b = {dev, 1'b1};
    endcase
    return b;
  endfunction

  state_t           r_state, w_state;
  logic [DIV_W-1:0] r_div, w_div;
  logic [1:0]       r_q, w_q;
  logic [2:0]       r_bit, w_bit;
  logic [1:0]       r_seg, w_seg;
  logic [7:0]       r_sh, w_sh;
  logic             r_mid, w_mid;     // STOP is the mid-read one, not the final one
  logic             r_rw, w_rw;
  logic [6:0]       r_dev, w_dev;
  logic [7:0]       r_reg, w_reg;
  logic [7:0]       r_wdata, w_wdata;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_err, w_err;
  logic [7:0]       r_rdata, w_rdata;
  logic             r_scl, w_scl;
  logic             r_sda, w_sda;
  logic             w_tick;

  assign w_tick = (r_div == DIV_LAST);

  // Next-state and next-output logic for the bus sequencer.
  always_comb begin
    w_state = r_state;
    w_div   = r_div;
    w_q     = r_q;
    w_bit   = r_bit;
    w_seg   = r_seg;
    w_sh    = r_sh;
    w_mid   = r_mid;
    w_rw    = r_rw;
    w_dev   = r_dev;
    w_reg   = r_reg;
    w_wdata = r_wdata;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_err   = r_err;
    w_rdata = r_rdata;
    w_scl   = r_scl;
    w_sda   = r_sda;
    case (r_state)
      ST_IDLE: begin
        w_div = {DIV_W{1'b0}};
        if (start) begin
          w_rw    = rw;
          w_dev   = dev_addr;
          w_reg   = reg_addr;
          w_wdata = wdata;
          w_err   = 1'b0;
          w_busy  = 1'b1;
          w_seg   = SEG_DEV_W;
          w_mid   = 1'b0;
          w_q     = 2'd0;
          w_bit   = 3'd0;
          w_state = ST_START;
        end else begin
          w_busy = 1'b0;
        end
      end
      ST_DONE: begin
        w_div   = {DIV_W{1'b0}};
        w_busy  = 1'b0;
        w_done  = 1'b1;
        w_state = ST_IDLE;
      end
      default: begin
        if (w_tick) begin
          w_div = {DIV_W{1'b0}};
          w_q   = r_q + 2'd1;
          case (r_state)
            ST_START: begin
              case (r_q)
                2'd0: w_sda = 1'b0;
                2'd1: w_scl = 1'b1;
                2'd2: w_scl = 1'b1;
                default: begin
                  w_scl   = 1'b0;
                  w_sh    = seg_byte(r_seg, r_dev, r_reg, r_wdata);
                  w_bit   = 3'd0;
                  w_state = ST_TX;
                end
              endcase
            end
            ST_TX: begin
              case (r_q)
                2'd0: w_sda = r_sh[7];
                2'd1: w_scl = 1'b1;
                2'd2: w_scl = 1'b1;
                default: begin
                  w_scl = 1'b0;
                  w_sh  = {r_sh[6:0], 1'b0};
                  if (r_bit == 3'd7) begin
                    w_bit   = 3'd0;
                    w_state = ST_ACK;
                  end else begin
                    w_bit = r_bit + 3'd1;
                  end
                end
              endcase
            end
            ST_ACK: begin
              case (r_q)
                2'd0: w_sda = 1'b1;
                2'd1: w_scl = 1'b1;
                2'd2: w_err = r_err | sda_i;
                default: begin
                  w_scl = 1'b0;
                  if (r_err) begin
                    w_state = ST_STOP;
                  end else begin
                    case (r_seg)
                      SEG_DEV_W: begin
                        w_seg   = SEG_REG;
                        w_sh    = seg_byte(SEG_REG, r_dev, r_reg, r_wdata);
                        w_state = ST_TX;
                      end
                      SEG_REG: begin
                        if (r_rw) begin
`ifdef I2C_REG_MASTER_RSTART_EN
                          w_state = ST_RSTART;
`else
                          w_mid   = 1'b1;
                          w_state = ST_STOP;
`endif
                        end else begin
                          w_seg   = SEG_DATA;
                          w_sh    = seg_byte(SEG_DATA, r_dev, r_reg, r_wdata);
                          w_state = ST_TX;
                        end
                      end
                      SEG_DATA: w_state = ST_STOP;
                      default:  w_state = ST_RX;
                    endcase
                  end
                end
              endcase
            end
            ST_RX: begin
              case (r_q)
                2'd0: w_sda = 1'b1;
                2'd1: w_scl = 1'b1;
                2'd2: w_sh  = {r_sh[6:0], sda_i};
                default: begin
                  w_scl = 1'b0;
                  if (r_bit == 3'd7) begin
                    w_bit   = 3'd0;
                    w_state = ST_NACK;
                  end else begin
                    w_bit = r_bit + 3'd1;
                  end
                end
              endcase
            end
            ST_NACK: begin
              case (r_q)
                2'd0: w_sda = 1'b1;
                2'd1: w_scl = 1'b1;
                2'd2: w_scl = 1'b1;
                default: begin
                  w_scl   = 1'b0;
                  w_rdata = r_sh;
                  w_state = ST_STOP;
                end
              endcase
            end
            ST_STOP: begin
              case (r_q)
                2'd0: w_sda = 1'b0;
                2'd1: w_scl = 1'b1;
                2'd2: w_sda = 1'b1;
                default: begin
                  if (r_mid) begin
                    w_mid   = 1'b0;
                    w_seg   = SEG_DEV_R;
                    w_state = ST_START;
                  end else begin
                    w_state = ST_DONE;
                  end
                end
              endcase
            end
            ST_RSTART: begin
              case (r_q)
                2'd0: w_sda = 1'b1;
                2'd1: w_scl = 1'b1;
                2'd2: w_sda = 1'b0;
                default: begin
                  w_scl   = 1'b0;
                  w_seg   = SEG_DEV_R;
                  w_sh    = seg_byte(SEG_DEV_R, r_dev, r_reg, r_wdata);
                  w_bit   = 3'd0;
                  w_state = ST_TX;
                end
              endcase
            end
            default: w_state = ST_IDLE;
          endcase
        end else begin
          w_div = r_div + 1'b1;
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_div   <= {DIV_W{1'b0}};
      r_q     <= 2'd0;
      r_bit   <= 3'd0;
      r_seg   <= SEG_DEV_W;
      r_sh    <= 8'h00;
      r_mid   <= 1'b0;
      r_rw    <= 1'b0;
      r_dev   <= 7'h00;
      r_reg   <= 8'h00;
      r_wdata <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 8'h00;
      r_scl   <= 1'b1;
      r_sda   <= 1'b1;
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_q     <= w_q;
      r_bit   <= w_bit;
      r_seg   <= w_seg;
      r_sh    <= w_sh;
      r_mid   <= w_mid;
      r_rw    <= w_rw;
      r_dev   <= w_dev;
      r_reg   <= w_reg;
      r_wdata <= w_wdata;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_err   <= w_err;
      r_rdata <= w_rdata;
      r_scl   <= w_scl;
      r_sda   <= w_sda;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign ack_err = r_err;
  assign rdata   = r_rdata;
  assign scl_o   = r_scl;
  assign sda_o   = r_sda;

endmodule

// File: tb/tb_i2c_reg_master.sv
// Directed bench for i2c_reg_master with CLK_DIV=4 and a behavioural
// register slave at 0x5A that ACKs its address and returns 0x3C on reads.
module tb_i2c_reg_master;

  localparam int CLK_DIV = 4;
  localparam int EV_S = 256, EV_P = 257, EV_MACK = 258, EV_MNACK = 259;
  localparam int M_IDLE = 0, M_RX = 1, M_ACK = 2, M_TX = 3, M_MACK = 4;

  logic       clk = 1'b0;
  logic       rst, start, rw;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr, wdata;
  logic       busy, done, ack_err, scl_o, sda_o, sda_i;
  logic [7:0] rdata;

  always #5 clk = ~clk;

  i2c_reg_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .wdata(wdata), .busy(busy), .done(done),
    .ack_err(ack_err), .rdata(rdata), .scl_o(scl_o), .sda_o(sda_o), .sda_i(sda_i)
  );

  // Slave model state
  logic       sl_drv = 1'b1;
  logic       p_scl = 1'b1, p_sda = 1'b1, rst_d = 1'b1;
  logic [7:0] sh = 8'h00;
  logic [7:0] rd_data = 8'h3C;
  logic [6:0] slv_addr = 7'h5A;
  logic       first = 1'b0, rd = 1'b0;
  int         mode = M_IDLE, nb = 0, tb = 0, viol = 0;
  int         ev[$];
  int         exp_ev[$];
  int         n_vec = 0, n_bad = 0;

  assign sda_i = sda_o & sl_drv;

  // Bus decoder, slave responder and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      rst_d <= 1'b1; p_scl <= 1'b1; p_sda <= 1'b1; sl_drv <= 1'b1;
      mode <= M_IDLE; nb <= 0; tb <= 0; first <= 1'b0; rd <= 1'b0;
    end else begin
      rst_d <= 1'b0; p_scl <= scl_o; p_sda <= sda_o;
      if (!rst_d && (p_scl != scl_o) && (p_sda != sda_o)) viol <= viol + 1;
      if (p_scl && scl_o && p_sda && !sda_o) begin
        ev.push_back(EV_S); mode <= M_RX; nb <= 0; first <= 1'b1; sl_drv <= 1'b1;
      end else if (p_scl && scl_o && !p_sda && sda_o) begin
        ev.push_back(EV_P); mode <= M_IDLE; sl_drv <= 1'b1;
      end else if (!p_scl && scl_o) begin
        if (mode == M_RX) begin
          sh <= {sh[6:0], sda_o}; nb <= nb + 1;
        end else if (mode == M_MACK) begin
          ev.push_back(sda_o ? EV_MNACK : EV_MACK);
        end
      end else if (p_scl && !scl_o) begin
        case (mode)
          M_RX: if (nb == 8) begin
            ev.push_back(int'(sh));
            if (!first || sh[7:1] == slv_addr) begin
              sl_drv <= 1'b0; mode <= M_ACK; rd <= first && sh[0];
            end else begin
              mode <= M_IDLE;
            end
            first <= 1'b0;
          end
          M_ACK: if (rd) begin
            mode <= M_TX; sl_drv <= rd_data[7]; tb <= 1;
          end else begin
            sl_drv <= 1'b1; mode <= M_RX; nb <= 0;
          end
          M_TX: if (tb == 8) begin
            sl_drv <= 1'b1; mode <= M_MACK;
          end else begin
            sl_drv <= rd_data[7-tb]; tb <= tb + 1;
          end
          M_MACK: mode <= M_IDLE;
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_vec++;
    assert (obs >= lo && obs <= hi) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic chk_ev(input string tag);
    chk({tag, "_count"}, ev.size(), exp_ev.size());
    for (int i = 0; i < exp_ev.size() && i < ev.size(); i++)
      chk($sformatf("%s_%0d", tag, i), ev[i], exp_ev[i]);
  endtask

  task automatic issue(input logic r, input logic [6:0] d, input logic [7:0] ra, input logic [7:0] wd);
    rw = r; dev_addr = d; reg_addr = ra; wdata = wd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < limit);
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int n;
    int tot;
    rst = 1'b1; start = 1'b0; rw = 1'b0; dev_addr = 7'h00; reg_addr = 8'h00; wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ack_err", {31'd0, ack_err}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'h00);
    chk("rst_scl", {31'd0, scl_o}, 32'd1);
    chk("rst_sda", {31'd0, sda_o}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Register write 0x5A/0x10 <= 0xA5, with a stray start while busy
    ev.delete();
    issue(1'b0, 7'h5A, 8'h10, 8'hA5);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    chk("wr_sda_pre_edge", {31'd0, sda_o}, 32'd1);
    @(posedge clk); #1;
    chk("wr_sda_first_edge", {31'd0, sda_o}, 32'd0);
    chk("wr_scl_at_start", {31'd0, scl_o}, 32'd1);
    rw = 1'b1; dev_addr = 7'h22; reg_addr = 8'h77; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(2000, n);
    tot = 5 + n;
    chk_rng("wr_done_cycle", tot, 116*CLK_DIV+1, 116*CLK_DIV+3);
    chk("wr_ack_err", {31'd0, ack_err}, 32'd0);
    chk("wr_busy_at_done", {31'd0, busy}, 32'd0);
    exp_ev.delete();
    exp_ev.push_back(EV_S); exp_ev.push_back(32'hB4); exp_ev.push_back(32'h10);
    exp_ev.push_back(32'hA5); exp_ev.push_back(EV_P);
    chk_ev("wr_bytes");

    // Back-to-back read of register 0x10, issued while done is high
    ev.delete();
    issue(1'b1, 7'h5A, 8'h10, 8'h00);
    chk("b2b_done_pulse", {31'd0, done}, 32'd0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_scl_high", {31'd0, scl_o}, 32'd1);
    chk("b2b_sda_high", {31'd0, sda_o}, 32'd1);
    wait_done(2000, n);
`ifdef I2C_REG_MASTER_RSTART_EN
    chk_rng("rd_done_cycle", n, 156*CLK_DIV+1, 156*CLK_DIV+3);
`else
    chk_rng("rd_done_cycle", n, 160*CLK_DIV+1, 160*CLK_DIV+3);
`endif
    chk("rd_rdata", {24'd0, rdata}, 32'h3C);
    chk("rd_ack_err", {31'd0, ack_err}, 32'd0);
    exp_ev.delete();
    exp_ev.push_back(EV_S); exp_ev.push_back(32'hB4); exp_ev.push_back(32'h10);
`ifndef I2C_REG_MASTER_RSTART_EN
    exp_ev.push_back(EV_P);
`endif
    exp_ev.push_back(EV_S); exp_ev.push_back(32'hB5); exp_ev.push_back(EV_MNACK);
    exp_ev.push_back(EV_P);
    chk_ev("rd_bytes");

    // Nobody answers at 0x22
    repeat (3) begin @(posedge clk); #1; end
    ev.delete();
    issue(1'b0, 7'h22, 8'h10, 8'h55);
    wait_done(2000, n);
    chk_rng("nack_done_cycle", n, 44*CLK_DIV+1, 44*CLK_DIV+3);
    chk("nack_ack_err", {31'd0, ack_err}, 32'd1);
    chk("nack_rdata_kept", {24'd0, rdata}, 32'h3C);
    exp_ev.delete();
    exp_ev.push_back(EV_S); exp_ev.push_back(32'h44); exp_ev.push_back(EV_P);
    chk_ev("nack_bytes");
    repeat (5) begin @(posedge clk); #1; end
    chk("nack_err_held", {31'd0, ack_err}, 32'd1);

    // Reset in the middle of the register-address byte
    issue(1'b0, 7'h5A, 8'h33, 8'h11);
    chk("start_clears_err", {31'd0, ack_err}, 32'd0);
    repeat (180) begin @(posedge clk); #1; end
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_scl", {31'd0, scl_o}, 32'd1);
    chk("mrst_sda", {31'd0, sda_o}, 32'd1);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_rdata", {24'd0, rdata}, 32'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // The following command runs normally
    ev.delete();
    issue(1'b0, 7'h5A, 8'h20, 8'h5C);
    wait_done(2000, n);
    chk_rng("post_done_cycle", n, 116*CLK_DIV+1, 116*CLK_DIV+3);
    chk("post_ack_err", {31'd0, ack_err}, 32'd0);
    chk("post_rdata", {24'd0, rdata}, 32'h00);
    exp_ev.delete();
    exp_ev.push_back(EV_S); exp_ev.push_back(32'hB4); exp_ev.push_back(32'h20);
    exp_ev.push_back(32'h5C); exp_ev.push_back(EV_P);
    chk_ev("post_bytes");

    repeat (4) begin @(posedge clk); #1; end
    chk("protocol_sda_vs_scl", viol, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
